// File: rtl/block_memory_responder_pkg.sv
// Shared types and constants for the cache<->memory block interface.
// Holds the request/response structs, the geometry of the backing array,
// the responder state encoding and a constant-evaluable clog2 helper.
package block_memory_responder_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int WORD_WIDTH  = 32;
    localparam int BLOCK_SIZE  = 2;
    localparam int MEM_LATENCY = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int OFFSET_WIDTH = clog2(BLOCK_SIZE);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]                 addr;
        logic                                  cs;
        logic                                  rw;   // 0 read, 1 write
        logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
    } memory_request_t;

    typedef struct packed {
        logic                                  ack;
        logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
    } memory_response_t;

    typedef enum logic [1:0] {
        mem_idle,
        mem_wait,
        mem_ack
    } mem_state_t;

endpackage

// File: rtl/block_memory_responder_if.sv
// Block-transfer bus between cache controller (master) and memory (slave).
//   mem_req  : request from the cache (addr, cs, rw, write data)
//   mem_resp : response from memory (ack, read data)
interface block_memory_responder_if;
    import block_memory_responder_pkg::*;

    memory_request_t  mem_req;
    memory_response_t mem_resp;

    modport master (output mem_req, input  mem_resp);
    modport slave  (input  mem_req, output mem_resp);
endinterface

// File: rtl/block_memory_responder_latency_counter.sv
// Loadable down-counter that times the array access latency.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load LATENCY-1 (takes priority over en)
//   en         : decrement by one, holding at zero
//   zero       : count is zero
module mem_latency_counter
    import block_memory_responder_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CW = clog2(LATENCY + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LATENCY - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/block_memory_responder.sv
// Main-memory responder: services aligned block reads/writes from the cache
// after a fixed latency and answers with a 4-phase cs/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset (array is not reset)
//   bus        : slave side of block_memory_responder_if (mem_req in, mem_resp out)
//   busy       : high whenever the FSM is not idle
//   rd_count, wr_count : completed read/write counters, saturating
//                        (present only when MEM_STATS_EN is defined)
//
// state    | meaning
// mem_idle | waiting for cs; on cs, latch request and start the latency timer
// mem_wait | timing the access; cs drop aborts, timer expiry commits
// mem_ack  | ack held with stable data until cs drops
module block_memory_responder
    import block_memory_responder_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    block_memory_responder_if.slave  bus,
    output logic                     busy
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count
`endif
);
    typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

    mem_state_t            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  rw_q;
    block_t                wdata_q;
    block_t                rdata_q;
    logic                  ack_q;
    logic                  cnt_zero;
    logic                  commit;

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign commit = (state == mem_wait) && bus.mem_req.cs && cnt_zero;

    mem_latency_counter #(.LATENCY(LATENCY)) u_latency (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state == mem_idle) && bus.mem_req.cs),
        .en    ((state == mem_wait) && bus.mem_req.cs),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= mem_idle;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            base_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                mem_idle: begin
                    if (bus.mem_req.cs) begin
                        // Block-aligned base, so base+i never leaves the block.
                        base_q  <= bus.mem_req.addr & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
                        rw_q    <= bus.mem_req.rw;
                        wdata_q <= bus.mem_req.data;
                        state   <= mem_wait;
                    end
                end
                mem_wait: begin
                    if (!bus.mem_req.cs) begin
                        state <= mem_idle;
                    end else if (cnt_zero) begin
                        if (!rw_q) begin
                            for (int i = 0; i < BLOCK_SIZE; i++) begin
                                rdata_q[i] <= mem[base_q | ADDR_WIDTH'(i)];
                            end
                        end
                        ack_q <= 1'b1;
                        state <= mem_ack;
                    end
                end
                mem_ack: begin
                    if (!bus.mem_req.cs) begin
                        ack_q <= 1'b0;
                        state <= mem_idle;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= mem_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit && rw_q) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem[base_q | ADDR_WIDTH'(i)] <= wdata_q[i];
            end
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (commit) begin
            if (!rw_q && rd_count != '1) rd_count <= rd_count + 32'd1;
            if (rw_q && wr_count != '1)  wr_count <= wr_count + 32'd1;
        end
    end
`endif

    assign bus.mem_resp.ack  = ack_q;
    assign bus.mem_resp.data = rdata_q;
    assign busy              = (state != mem_idle);
endmodule
